// File: rtl/imem_arbiter_if.sv
// Bus bundle for the instruction-memory arbiter: fetch port, loader port and memory side.
// The slave modport is the arbiter's view; master is the environment driving it.
interface imem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;

  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_wdata_i;
  logic        ld_done_i;
  logic        ld_gnt_o;
  logic        ld_err_o;
  logic [11:0] ld_count_o;
  logic        boot_done_o;

  logic        mem_en_o;
  logic        mem_we_o;
  logic [10:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  ld_req_i, ld_addr_i, ld_wdata_i, ld_done_i,
    output ld_gnt_o, ld_err_o, ld_count_o, boot_done_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output ld_req_i, ld_addr_i, ld_wdata_i, ld_done_i,
    input  ld_gnt_o, ld_err_o, ld_count_o, boot_done_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port instruction memory between a boot loader (writes) and
// instruction fetch (reads); the loader owns the memory until it signals end of image.
module imem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  imem_arbiter_if.slave  bus
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [11:0] COUNT_MAX  = 12'd2048;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic [11:0] ld_count_q, ld_count_d;
  logic        rvalid_q, rvalid_d;
  logic        ferr_q, ferr_d;
  logic        ld_err_q, ld_err_d;

  logic        if_gnt;
  logic        ld_gnt;
  logic        if_in_range;
  logic        ld_in_range;

  assign if_in_range = (bus.if_addr_i[31:13] == 19'd0) && (bus.if_addr_i[1:0] == 2'd0);
  assign ld_in_range = (bus.ld_addr_i[31:13] == 19'd0) && (bus.ld_addr_i[1:0] == 2'd0);

  // Grants are forced low while reset is held so no access leaks out mid-reset.
  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    ld_gnt  = 1'b0;
    if (rst_ni) begin
      case (state_q)
        BOOT: begin
          ld_gnt = bus.ld_req_i;
          if (bus.ld_done_i) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.if_req_i && (!bus.ld_req_i || starve_q == STARVE_LIM)) begin
            if_gnt = 1'b1;
          end else begin
            ld_gnt = bus.ld_req_i;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req_i || if_gnt) begin
      starve_d = 3'd0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_comb begin
    ld_count_d = ld_count_q;
    if (ld_gnt && ld_in_range && ld_count_q != COUNT_MAX) begin
      ld_count_d = ld_count_q + 12'd1;
    end
  end

  // Out-of-range fetches are still accepted; they skip the memory and return a NOP with error.
  always_comb begin
    rvalid_d = if_gnt;
    ferr_d   = if_gnt && !if_in_range;
    ld_err_d = ld_gnt && !ld_in_range;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      starve_q   <= 3'd0;
      ld_count_q <= 12'd0;
      rvalid_q   <= 1'b0;
      ferr_q     <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ld_count_q <= ld_count_d;
      rvalid_q   <= rvalid_d;
      ferr_q     <= ferr_d;
      ld_err_q   <= ld_err_d;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ld_gnt_o    = ld_gnt;
  assign bus.mem_en_o    = (if_gnt && if_in_range) || ld_gnt;
  assign bus.mem_we_o    = ld_gnt && ld_in_range;
  assign bus.mem_addr_o  = if_gnt ? bus.if_addr_i[12:2] : bus.ld_addr_i[12:2];
  assign bus.mem_wdata_o = bus.ld_wdata_i;

  assign bus.if_rvalid_o = rvalid_q;
  assign bus.if_err_o    = rvalid_q && ferr_q;
  assign bus.if_rdata_o  = !rvalid_q ? 32'd0 : (ferr_q ? NOP_INSN : bus.mem_rdata_i);

  assign bus.ld_err_o    = ld_err_q;
  assign bus.ld_count_o  = ld_count_q;
  assign bus.boot_done_o = (state_q == RUN);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: stimulus pushes expected fetch responses into a
// queue and an independent monitor pops them whenever the DUT raises if_rvalid_o.
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_arbiter_if bus();

  imem_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  logic [31:0] mem [2048] = '{default: 32'd0};

  // Synchronous single-port RAM model: read data one cycle after a read strobe.
  always @(posedge clk) begin
    if (bus.mem_en_o && bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
    bus.mem_rdata_i <= (bus.mem_en_o && !bus.mem_we_o) ? mem[bus.mem_addr_o] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return (a[31:13] == 19'd0) && (a[1:0] == 2'd0);
  endfunction

  always @(negedge clk) begin
    if (bus.if_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected no response pending");
      end else begin
        mon_e = exp_q.pop_front();
        chk("if_rdata", bus.if_rdata_o, mon_e.rdata);
        chkb("if_err", bus.if_err_o, mon_e.err);
        $display("rsp: rdata=%h err=%b", bus.if_rdata_o, bus.if_err_o);
      end
    end else if (rst_n) begin
      chk("idle_rdata", bus.if_rdata_o, 32'd0);
      chkb("idle_err", bus.if_err_o, 1'b0);
    end
  end

  // One clock of stimulus; inputs change just after the rising edge, outputs checked at the falling edge.
  task automatic cyc(input logic ireq, input logic [31:0] iaddr,
                     input logic lreq, input logic [31:0] laddr, input logic [31:0] lwd,
                     input logic ldone, input logic exp_ig, input logic exp_lg,
                     input logic [31:0] exp_rd, input string tag);
    logic exp_en, exp_we;
    bus.if_req_i   = ireq;
    bus.if_addr_i  = iaddr;
    bus.ld_req_i   = lreq;
    bus.ld_addr_i  = laddr;
    bus.ld_wdata_i = lwd;
    bus.ld_done_i  = ldone;
    @(negedge clk);
    exp_en = (exp_ig && in_rng(iaddr)) || exp_lg;
    exp_we = exp_lg && in_rng(laddr);
    chkb({tag, ".if_gnt"}, bus.if_gnt_o, exp_ig);
    chkb({tag, ".ld_gnt"}, bus.ld_gnt_o, exp_lg);
    chkb({tag, ".mem_en"}, bus.mem_en_o, exp_en);
    chkb({tag, ".mem_we"}, bus.mem_we_o, exp_we);
    if (exp_en) chk({tag, ".mem_addr"}, 32'(bus.mem_addr_o), exp_ig ? 32'(iaddr[12:2]) : 32'(laddr[12:2]));
    if (exp_we) chk({tag, ".mem_wdata"}, bus.mem_wdata_o, lwd);
    if (exp_ig) exp_q.push_back({in_rng(iaddr) ? exp_rd : 32'h0000_0013, !in_rng(iaddr)});
    $display("cyc %s: if_req=%b if_addr=%h ld_req=%b ld_addr=%h if_gnt=%b ld_gnt=%b",
             tag, ireq, iaddr, lreq, laddr, bus.if_gnt_o, bus.ld_gnt_o);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_addr [6] = '{32'h04, 32'h08, 32'h0C, 32'h14, 32'h20, 32'h24};
  logic [31:0] b2b_data [6] = '{32'hA1, 32'hA2, 32'hA3, 32'hB2, 32'h00, 32'hB6};

  initial begin
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'd0;
    bus.ld_req_i = 1'b0; bus.ld_addr_i = 32'd0; bus.ld_wdata_i = 32'd0; bus.ld_done_i = 1'b0;

    // Requests during reset must not be granted.
    #2;
    bus.if_req_i = 1'b1;
    bus.ld_req_i = 1'b1;
    #1;
    chkb("rst.if_gnt", bus.if_gnt_o, 1'b0);
    chkb("rst.ld_gnt", bus.ld_gnt_o, 1'b0);
    chkb("rst.mem_en", bus.mem_en_o, 1'b0);
    chkb("rst.mem_we", bus.mem_we_o, 1'b0);
    chkb("rst.boot_done", bus.boot_done_o, 1'b0);
    chk("rst.ld_count", 32'(bus.ld_count_o), 32'd0);
    chkb("rst.if_rvalid", bus.if_rvalid_o, 1'b0);
    chkb("rst.ld_err", bus.ld_err_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // BOOT: loader writes while fetch is refused.
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 32'h40, 1'b1, 32'(k * 4), 32'hA0 + 32'(k), 1'b0, 1'b0, 1'b1, 32'd0, "boot_wr");
    chk("boot.ld_count", 32'(bus.ld_count_o), 32'd3);
    chkb("boot.boot_done", bus.boot_done_o, 1'b0);

    cyc(1'b0, 32'd0, 1'b1, 32'h0C, 32'hA3, 1'b1, 1'b0, 1'b1, 32'd0, "done_wr");
    chk("done.ld_count", 32'(bus.ld_count_o), 32'd4);
    chkb("done.boot_done", bus.boot_done_o, 1'b1);

    // RUN starvation: four loader grants, then fetch, then loader again.
    for (int k = 1; k <= 6; k++)
      cyc(1'b1, 32'h0, 1'b1, 32'h10 + 32'((k - 1) * 4), 32'hB0 + 32'(k), (k == 6),
          (k == 5), (k != 5), 32'hA0, "starve");
    chk("starve.ld_count", 32'(bus.ld_count_o), 32'd9);
    chkb("starve.boot_done", bus.boot_done_o, 1'b1);

    // Back-to-back fetches, one response per cycle.
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, b2b_addr[k], 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, b2b_data[k], "b2b_fetch");
      chkb("b2b.if_rvalid", bus.if_rvalid_o, 1'b1);
    end
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "idle");

    // Out-of-range fetches return NOP with error.
    cyc(1'b1, 32'h2000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, "oor_fetch");
    chkb("oor_fetch.if_err", bus.if_err_o, 1'b1);
    cyc(1'b1, 32'h2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, "mis_fetch");
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "idle");

    // Out-of-range loader write is granted but dropped.
    cyc(1'b0, 32'd0, 1'b1, 32'h6, 32'hDEAD, 1'b0, 1'b0, 1'b1, 32'd0, "oor_wr");
    chkb("oor_wr.ld_err", bus.ld_err_o, 1'b1);
    chk("oor_wr.ld_count", 32'(bus.ld_count_o), 32'd9);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "idle");
    chkb("oor_wr.ld_err_clear", bus.ld_err_o, 1'b0);
    cyc(1'b1, 32'h0C, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hA3, "post_err_fetch");

    // Reset with a read in flight: the response must be discarded.
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0; bus.ld_req_i = 1'b0; bus.ld_done_i = 1'b0;
    @(negedge clk);
    chkb("inflight.if_gnt", bus.if_gnt_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chkb("inflight.if_rvalid", bus.if_rvalid_o, 1'b0);
    chkb("inflight.boot_done", bus.boot_done_o, 1'b0);
    chkb("inflight.if_gnt_rst", bus.if_gnt_o, 1'b0);
    chkb("inflight.mem_en", bus.mem_en_o, 1'b0);
    chk("inflight.ld_count", 32'(bus.ld_count_o), 32'd0);
    @(posedge clk);
    #1;
    chkb("inflight.if_rvalid_edge", bus.if_rvalid_o, 1'b0);
    bus.if_req_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "post_rst_idle");
    chkb("post_rst.if_rvalid", bus.if_rvalid_o, 1'b0);
    cyc(1'b1, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "post_rst_boot_fetch");
    chkb("post_rst.boot_done", bus.boot_done_o, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "idle");

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
